demo_sequencer: RTL and testbench
=================================

# demo_sequencer

Frame-synchronous scene scheduler for the VGA demo. Counts frames from the VGA timing generator's frame-start pulse, steps through a fixed list of scenes, and produces the scene select, per-scene frame counter and global fade level that the effect datapath consumes. It sits between the timing generator, the effect renderers and the Tiny Tapeout `ui_in` pins, which provide pause, skip and manual scene override.

## Interface
Parameters:
- `NUM_SCENES`, 4: number of scenes, a power of two; `scene` wraps modulo this value.
- `FRAME_W`, 10: width of `scene_frame`.

Ports:
- `clk48` in 1: 48 MHz pixel-domain clock.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse from the timing generator at the start of vblank.
- `pause_in` in 1: raw pin, asynchronous; high freezes sequencing.
- `skip_in` in 1: raw pin, asynchronous; a rising edge requests the next scene.
- `manual_en` in 1: raw pin, asynchronous; high selects manual scene override.
- `manual_scene` in log2(NUM_SCENES): raw pins, asynchronous; target scene when `manual_en` is high.
- `scene` out log2(NUM_SCENES): current scene index.
- `scene_frame` out FRAME_W: frames elapsed since scene entry, saturating.
- `fade` out 4: brightness, 0 is black and 15 is full.
- `scene_change` out 1: one-cycle pulse, coincident with a new `scene` value.

## Operation
- All pin inputs pass through 2-FF synchronizers. `skip_in` is then edge-detected.
- A synchronized skip rising edge sets a sticky `skip_pend` flag. The flag is consumed, and cleared, at the next unpaused `frame_start`.
- State machine states: FADE_IN, HOLD, FADE_OUT. Transitions are evaluated only on `frame_start` with pause low.
- FADE_IN:
  - `fade` increments by 1 per frame.
  - At a `frame_start` with `fade` = 14, `fade` becomes 15 and the state moves to HOLD with `hold_cnt` = 0.
- HOLD:
  - `fade` = 15 and `hold_cnt` increments.
  - The state moves to FADE_OUT when any of these hold:
    - `hold_cnt` = `SCENE_LEN[scene]` − 1;
    - `skip_pend` is set;
    - `manual_en` is high and `manual_scene` ≠ `scene`.
- FADE_OUT:
  - `fade` decrements by 1 per frame.
  - At a `frame_start` with `fade` = 0, the scene advances, the state moves to FADE_IN with `fade` = 0, and `scene_frame` is cleared.
- Skip and manual override in FADE_IN move the state straight to FADE_OUT, keeping the current `fade` value. In FADE_OUT they are absorbed and `skip_pend` is cleared.
- Next scene:
  - If `manual_en` is high, the next scene is `manual_scene`.
  - Otherwise it is `scene` + 1, wrapping from NUM_SCENES−1 to 0.
- `scene_frame` increments on every unpaused `frame_start`, saturates at 2^FRAME_W − 1, and is cleared on scene change.
- Pause high means `frame_start` is ignored entirely: no counter, state or output changes. Skip edges arriving while paused are discarded.

## Timing
- Reset values:
  - state = FADE_IN;
  - `scene` = 0, `scene_frame` = 0, `fade` = 0;
  - `scene_change` = 0, `skip_pend` = 0;
  - synchronizers cleared.
- All outputs are registered. They change only in the cycle after a `frame_start` pulse (1-cycle latency), so no output changes during active video.
- Input latency: 2 cycles for synchronization, plus 1 cycle for edge detection, before `skip_pend` sets.
- If a skip edge registers in the same cycle as `frame_start`, it applies at that same `frame_start`.
- `rst` asserted mid-frame clears everything immediately. The FSM then waits for the next `frame_start`.

## Configuration
- `DEMO_FADE_EN` defined: full FADE_IN / HOLD / FADE_OUT behaviour as described above.
- `DEMO_FADE_EN` undefined:
  - FADE states are removed; the reset state is HOLD and `fade` is tied to 15.
  - The scene advances directly at the HOLD exit conditions, with `scene_change` pulsing in that same update.

## Structure
- Package `demo_pkg`:
  - `SCENE_LEN` constant array: {120, 240, 90, 180} frames;
  - state enum `seq_state_t`;
  - `FADE_MAX` = 15.
- Sub-module `demo_input_sync`: 2-FF synchronizer plus rising-edge detector. Instantiated once per pin group.

## Test plan
- Reset, then 15 `frame_start` pulses: `fade` steps 0→15, state = HOLD, `scene` = 0, `scene_frame` = 15.
- Continue a further 120 + 15 frames: `fade` is 15 throughout HOLD, then ramps 15→0. The next `frame_start` gives `scene` = 1, one `scene_change` pulse, `fade` = 0 and `scene_frame` = 0.
- Skip edge at HOLD frame 10 of scene 2: FADE_OUT begins at the next `frame_start`, and `scene` = 3 follows 16 frames later. From scene 3, the next advance wraps to 0.
- `manual_en` = 1, `manual_scene` = 2 while in scene 0 HOLD: fade-out runs and `scene` becomes 2, skipping scene 1.
- `pause_in` high across 50 `frame_start` pulses plus a skip edge: no output changes and no skip applied after release.
- Without `DEMO_FADE_EN`: `fade` = 15 at all times, and `scene` = 1 after exactly 120 `frame_start` pulses from reset.

Source files
------------

// File: rtl/demo_pkg.sv
// demo_pkg: shared constants, state encoding and scene-length lookup for the demo sequencer.
// Build option: DEMO_FADE_EN selects the fade-in / hold / fade-out sequencing.
`default_nettype none

package demo_pkg;

    localparam int SCENE_CNT = 4;
    localparam int HOLD_W    = 8;

    // Hold length in frames for each scene; entry 0 is the least-significant byte.
    localparam logic [SCENE_CNT-1:0][HOLD_W-1:0] SCENE_LEN = {8'd180, 8'd90, 8'd240, 8'd120};

    localparam logic [3:0] FADE_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_FADE_IN  = 2'd0,
        ST_HOLD     = 2'd1,
        ST_FADE_OUT = 2'd2
    } seq_state_t;

    function automatic logic [HOLD_W-1:0] scene_last(input logic [1:0] idx);
        return SCENE_LEN[idx] - 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demo_input_sync.sv
// demo_input_sync: 2-FF synchronizer for a group of asynchronous pins, plus a rising-edge
// detector on the synchronized value. Build option DEMO_FADE_EN does not affect this block.
`default_nettype none

module demo_input_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk48,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            meta_r <= '0;
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync_out = sync_r;
    assign rise     = sync_r & ~prev_r;

endmodule

`default_nettype wire

// File: rtl/demo_sequencer.sv
// demo_sequencer: frame-synchronous scene scheduler producing scene select, per-scene frame
// count and fade level. Build option DEMO_FADE_EN enables the fade-in / fade-out ramps.
`default_nettype none

module demo_sequencer
    import demo_pkg::*;
#(
    parameter int NUM_SCENES = 4,
    parameter int FRAME_W    = 10
) (
    input  logic                          clk48,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          pause_in,
    input  logic                          skip_in,
    input  logic                          manual_en,
    input  logic [$clog2(NUM_SCENES)-1:0] manual_scene,
    output logic [$clog2(NUM_SCENES)-1:0] scene,
    output logic [FRAME_W-1:0]            scene_frame,
    output logic [3:0]                    fade,
    output logic                          scene_change
);

    localparam int SCENE_W = $clog2(NUM_SCENES);
    localparam int LVL_W   = SCENE_W + 2;

`ifdef DEMO_FADE_EN
    localparam seq_state_t ST_RESET = ST_FADE_IN;
`else
    localparam seq_state_t ST_RESET = ST_HOLD;
`endif

    logic [LVL_W-1:0]   lvl_sync;
    logic [LVL_W-1:0]   unused_lvl_rise;
    logic               skip_sync_unused;
    logic               skip_rise;
    logic               pause_s;
    logic               manual_en_s;
    logic [SCENE_W-1:0] manual_scene_s;

    demo_input_sync #(.WIDTH(LVL_W)) u_sync_lvl (
        .clk48    (clk48),
        .rst      (rst),
        .async_in ({pause_in, manual_en, manual_scene}),
        .sync_out (lvl_sync),
        .rise     (unused_lvl_rise)
    );

    demo_input_sync #(.WIDTH(1)) u_sync_skip (
        .clk48    (clk48),
        .rst      (rst),
        .async_in (skip_in),
        .sync_out (skip_sync_unused),
        .rise     (skip_rise)
    );

    assign {pause_s, manual_en_s, manual_scene_s} = lvl_sync;

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [SCENE_W-1:0] scene_r,  scene_nxt;
    logic [FRAME_W-1:0] frame_r,  frame_nxt;
    logic [HOLD_W-1:0]  hold_r,   hold_nxt;
    logic               pend_r,   pend_nxt;
    logic               change_r, change_nxt;
`ifdef DEMO_FADE_EN
    logic [3:0]         fade_r,   fade_nxt;
`endif

    logic               tick;
    logic               leave;
    logic               hold_done;
    logic [SCENE_W-1:0] next_scene;

    // A skip edge seen in the same cycle as frame_start counts at that frame.
    assign tick       = frame_start & ~pause_s;
    assign leave      = pend_r | skip_rise | (manual_en_s & (manual_scene_s != scene_r));
    assign hold_done  = (hold_r == scene_last(2'(scene_r)));
    assign next_scene = manual_en_s ? manual_scene_s : scene_r + SCENE_W'(1);

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state    <= ST_RESET;
            scene_r  <= '0;
            frame_r  <= '0;
            hold_r   <= '0;
            pend_r   <= 1'b0;
            change_r <= 1'b0;
`ifdef DEMO_FADE_EN
            fade_r   <= 4'd0;
`endif
        end else begin
            state    <= state_nxt;
            scene_r  <= scene_nxt;
            frame_r  <= frame_nxt;
            hold_r   <= hold_nxt;
            pend_r   <= pend_nxt;
            change_r <= change_nxt;
`ifdef DEMO_FADE_EN
            fade_r   <= fade_nxt;
`endif
        end
    end

    always_comb begin : p_next_state
        state_nxt = state;
`ifdef DEMO_FADE_EN
        if (tick) begin
            case (state)
                ST_FADE_IN: begin
                    if (leave)
                        state_nxt = ST_FADE_OUT;
                    else if (fade_r == FADE_MAX - 4'd1)
                        state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_done || leave)
                        state_nxt = ST_FADE_OUT;
                end
                ST_FADE_OUT: begin
                    if (fade_r == 4'd0)
                        state_nxt = ST_FADE_IN;
                end
                default: state_nxt = ST_FADE_IN;
            endcase
        end
`else
        state_nxt = ST_HOLD;
`endif
    end

    always_comb begin : p_datapath
        scene_nxt  = scene_r;
        frame_nxt  = frame_r;
        hold_nxt   = hold_r;
        change_nxt = 1'b0;
        // Skip edges while paused are dropped; any pending skip is consumed by the next frame.
        pend_nxt   = pend_r | (skip_rise & ~pause_s);
`ifdef DEMO_FADE_EN
        fade_nxt   = fade_r;
`endif
        if (tick) begin
            pend_nxt  = 1'b0;
            frame_nxt = (frame_r == {FRAME_W{1'b1}}) ? frame_r : frame_r + FRAME_W'(1);
            case (state)
`ifdef DEMO_FADE_EN
                ST_FADE_IN: begin
                    hold_nxt = '0;
                    if (!leave)
                        fade_nxt = fade_r + 4'd1;
                end
                ST_HOLD: begin
                    hold_nxt = hold_r + HOLD_W'(1);
                end
                ST_FADE_OUT: begin
                    hold_nxt = '0;
                    if (fade_r == 4'd0) begin
                        scene_nxt  = next_scene;
                        frame_nxt  = '0;
                        change_nxt = 1'b1;
                    end else begin
                        fade_nxt = fade_r - 4'd1;
                    end
                end
`else
                ST_HOLD: begin
                    if (hold_done || leave) begin
                        scene_nxt  = next_scene;
                        frame_nxt  = '0;
                        hold_nxt   = '0;
                        change_nxt = 1'b1;
                    end else begin
                        hold_nxt = hold_r + HOLD_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign scene        = scene_r;
    assign scene_frame  = frame_r;
    assign scene_change = change_r;
`ifdef DEMO_FADE_EN
    assign fade         = fade_r;
`else
    assign fade         = FADE_MAX;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demo_sequencer.sv
// tb_demo_sequencer: randomized and directed checks of demo_sequencer against a frame-level
// reference model. Honours DEMO_FADE_EN the same way as the design.
`default_nettype none
`timescale 1ns/1ps

module tb_demo_sequencer;

    localparam int MODE_IN   = 0;
    localparam int MODE_HOLD = 1;
    localparam int MODE_OUT  = 2;

    logic       clk48 = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       pause_in;
    logic       skip_in;
    logic       manual_en;
    logic [1:0] manual_scene;
    logic [1:0] scene;
    logic [9:0] scene_frame;
    logic [3:0] fade;
    logic       scene_change;

    always #10 clk48 = ~clk48;

    demo_sequencer #(.NUM_SCENES(4), .FRAME_W(10)) dut (
        .clk48        (clk48),
        .rst          (rst),
        .frame_start  (frame_start),
        .pause_in     (pause_in),
        .skip_in      (skip_in),
        .manual_en    (manual_en),
        .manual_scene (manual_scene),
        .scene        (scene),
        .scene_frame  (scene_frame),
        .fade         (fade),
        .scene_change (scene_change)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_scene, m_frame, m_fade, m_mode, m_hold;
    bit m_pend, m_change;
    bit p_pause, p_men;
    int p_mscene;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int len_of(input int s);
        case (s % 4)
            0:       return 120;
            1:       return 240;
            2:       return 90;
            default: return 180;
        endcase
    endfunction

    task automatic model_reset();
        m_scene  = 0;
        m_frame  = 0;
        m_hold   = 0;
        m_pend   = 0;
        m_change = 0;
`ifdef DEMO_FADE_EN
        m_mode = MODE_IN;
        m_fade = 0;
`else
        m_mode = MODE_HOLD;
        m_fade = 15;
`endif
    endtask

    task automatic model_advance();
        m_scene  = p_men ? p_mscene : (m_scene + 1) % 4;
        m_frame  = 0;
        m_hold   = 0;
        m_change = 1;
        m_mode   = (m_fade == 15 && m_mode == MODE_HOLD) ? MODE_HOLD : MODE_IN;
    endtask

    task automatic model_frame(input bit skip_same);
        bit leave;
        m_change = 0;
        if (p_pause) return;
        leave  = m_pend || skip_same || (p_men && p_mscene != m_scene);
        m_pend = 0;
        if (m_frame < 1023) m_frame++;
`ifdef DEMO_FADE_EN
        case (m_mode)
            MODE_IN: begin
                if (leave) m_mode = MODE_OUT;
                else begin
                    m_fade++;
                    if (m_fade == 15) begin
                        m_mode = MODE_HOLD;
                        m_hold = 0;
                    end
                end
            end
            MODE_HOLD: begin
                if (m_hold == len_of(m_scene) - 1 || leave) m_mode = MODE_OUT;
                else m_hold++;
            end
            default: begin
                if (m_fade == 0) begin
                    model_advance();
                    m_mode = MODE_IN;
                end else m_fade--;
            end
        endcase
`else
        if (m_hold == len_of(m_scene) - 1 || leave) model_advance();
        else m_hold++;
`endif
    endtask

    task automatic set_pins(input bit pz, input bit men, input int ms);
        pause_in     = pz;
        manual_en    = men;
        manual_scene = 2'(ms);
        p_pause      = pz;
        p_men        = men;
        p_mscene     = ms;
    endtask

    task automatic do_frame(input bit skip_same);
        frame_start = 1'b1;
        @(negedge clk48);
        frame_start = 1'b0;
        model_frame(skip_same);
        chk("scene", int'(scene), m_scene);
        chk("scene_frame", int'(scene_frame), m_frame);
        chk("fade", int'(fade), m_fade);
        chk("scene_change", int'(scene_change), int'(m_change));
    endtask

    task automatic gap(input bit do_skip);
        repeat (4) @(negedge clk48);
        if (do_skip) begin
            skip_in = 1'b1;
            repeat (2) @(negedge clk48);
            skip_in = 1'b0;
            if (!p_pause) m_pend = 1;
        end
        repeat (5) @(negedge clk48);
        chk("gap_change", int'(scene_change), 0);
        chk("gap_scene", int'(scene), m_scene);
        chk("gap_fade", int'(fade), m_fade);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            do_frame(1'b0);
            gap(1'b0);
        end
    endtask

    initial begin
        int first_adv;
        int guard;
        rst         = 1'b1;
        frame_start = 1'b0;
        skip_in     = 1'b0;
        set_pins(1'b0, 1'b0, 0);
        model_reset();
        repeat (3) @(negedge clk48);
        chk("rst_scene", int'(scene), 0);
        chk("rst_frame", int'(scene_frame), 0);
        chk("rst_fade", int'(fade), m_fade);
        chk("rst_change", int'(scene_change), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk48);

        frames(15);
        chk("ramp_fade", int'(fade), 15);
        chk("ramp_frame", int'(scene_frame), 15);
        chk("ramp_scene", int'(scene), 0);

`ifdef DEMO_FADE_EN
        first_adv = 151;
`else
        first_adv = 120;
`endif
        frames(first_adv - 16);
        chk("pre_adv_scene", int'(scene), 0);
        do_frame(1'b0);
        chk("adv_scene", int'(scene), 1);
        chk("adv_change", int'(scene_change), 1);
        chk("adv_frame", int'(scene_frame), 0);
        gap(1'b0);

        frames(3);
        set_pins(1'b1, 1'b0, 0);
        gap(1'b0);
        for (int i = 0; i < 50; i++) begin
            do_frame(1'b0);
            gap(i == 25);
        end
        chk("pause_frame", int'(scene_frame), 3);
        set_pins(1'b0, 1'b0, 0);
        gap(1'b0);
        frames(5);
        chk("post_pause_scene", int'(scene), 1);

        repeat (3) @(negedge clk48);
        rst = 1'b1;
        #1;
        chk("midrst_scene", int'(scene), 0);
        chk("midrst_frame", int'(scene_frame), 0);
        chk("midrst_change", int'(scene_change), 0);
        model_reset();
        repeat (2) @(negedge clk48);
        rst = 1'b0;
        gap(1'b0);

        frames(20);
        set_pins(1'b0, 1'b1, 2);
        gap(1'b0);
        frames(40);
        chk("manual_scene", int'(scene), 2);
        set_pins(1'b0, 1'b0, 0);
        gap(1'b0);

        skip_in = 1'b1;
        repeat (2) @(negedge clk48);
        do_frame(1'b1);
        skip_in = 1'b0;
        gap(1'b0);
        frames(16);
        chk("skip_scene", int'(scene), 3);

        guard = 0;
        while (!m_change && guard < 400) begin
            do_frame(1'b0);
            gap(1'b0);
            guard++;
        end
        chk("wrap_seen", guard < 400, 1);
        chk("wrap_scene", int'(scene), 0);

        for (int i = 0; i < 1000; i++) begin
            bit pz, men, sk;
            int ms;
            pz = p_pause;
            men = p_men;
            ms = p_mscene;
            if ($urandom_range(39) == 0) pz = ~pz;
            if ($urandom_range(59) == 0) men = ~men;
            if ($urandom_range(19) == 0) ms = $urandom_range(3);
            sk = ($urandom_range(49) == 0);
            set_pins(pz, men, ms);
            gap(sk);
            do_frame(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
